// File: rtl/saradc_sar_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : saradc_sar_ctrl_if
// Description : Conversion handshake and analog SAR array signals.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface saradc_sar_ctrl_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic             cmp;
    logic             sample;
    logic             cmp_en;
    logic [NBITS-1:0] dac_code;
    logic [NBITS-1:0] dac_code_n;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] data;

    // master: the SAR controller; slave: digital wrapper plus analog array
    modport master (
        input  start, cmp,
        output sample, cmp_en, dac_code, dac_code_n, busy, done, data
    );

    modport slave (
        output start, cmp,
        input  sample, cmp_en, dac_code, dac_code_n, busy, done, data
    );
endinterface

`default_nettype wire

// File: rtl/saradc_sar_ctrl.sv
//------------------------------------------------------------------------------
// Module      : saradc_sar_ctrl
// Description : Successive-approximation controller, MSB-first, one bit/trial.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module saradc_sar_ctrl #(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    saradc_sar_ctrl_if.master  bus
);

    localparam int c_MAXC  = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int c_CNT_W = $clog2(c_MAXC + 1);
    localparam int c_IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO    = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SAMPLE_LOAD = c_CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [c_IDX_W-1:0] c_IDX_ZERO    = '0;
    localparam logic [c_IDX_W-1:0] c_IDX_ONE     = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_TOP     = c_IDX_W'(NBITS - 1);
    localparam logic [NBITS-1:0]   c_MSB         = NBITS'(1) << (NBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_sample;
    logic               r_cmp_en;
    logic               r_busy;
    logic               r_done;
    logic [NBITS-1:0]   r_dac_code;
    logic [NBITS-1:0]   r_data;

    logic [NBITS-1:0]   w_resolved;
    logic [NBITS-1:0]   w_next_trial;

    // Current trial with bit k decided by the comparator, and the next trial bit raised
    always_comb begin
        w_resolved        = r_dac_code;
        w_resolved[r_idx] = bus.cmp;
        w_next_trial      = w_resolved;
        if (r_idx != c_IDX_ZERO) begin
            w_next_trial[r_idx - c_IDX_ONE] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= c_CNT_ZERO;
            r_idx      <= c_IDX_ZERO;
            r_sample   <= 1'b0;
            r_cmp_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dac_code <= '0;
            r_data     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_SAMPLE;
                        r_sample   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_dac_code <= '0;
                        r_cnt      <= c_SAMPLE_LOAD;
                    end
                end
                ST_SAMPLE: begin
                    if (r_cnt == c_CNT_ZERO) begin
                        r_sample   <= 1'b0;
                        r_dac_code <= c_MSB;
                        r_idx      <= c_IDX_TOP;
                        if (SETTLE_CYCLES == 0) begin
                            r_state  <= ST_COMPARE;
                            r_cmp_en <= 1'b1;
                        end else begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= c_SETTLE_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == c_CNT_ZERO) begin
                        r_state  <= ST_COMPARE;
                        r_cmp_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                ST_COMPARE: begin
                    if (r_idx == c_IDX_ZERO) begin
                        r_dac_code <= w_resolved;
                        r_data     <= w_resolved;
                        r_cmp_en   <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_dac_code <= w_next_trial;
                        r_idx      <= r_idx - c_IDX_ONE;
                        // With no settling the strobe stays high across back-to-back trials
                        if (SETTLE_CYCLES != 0) begin
                            r_state  <= ST_SETTLE;
                            r_cmp_en <= 1'b0;
                            r_cnt    <= c_SETTLE_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_dac_code <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sample     = r_sample;
    assign bus.cmp_en     = r_cmp_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.data       = r_data;
    assign bus.dac_code   = r_dac_code;
    assign bus.dac_code_n = ~r_dac_code;

endmodule

`default_nettype wire

// File: tb/tb_saradc_sar_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_saradc_sar_ctrl
// Description : Directed bench for the SAR controller with ideal comparators.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_saradc_sar_ctrl;

    logic clk;
    logic rst;
    logic [7:0] vin_a;
    logic [3:0] vin_b;

    int n_assert;
    int n_fail;

    saradc_sar_ctrl_if #(.NBITS(8)) bus_a ();
    saradc_sar_ctrl_if #(.NBITS(4)) bus_b ();

    assign bus_a.cmp = bus_a.cmp_en && (vin_a >= bus_a.dac_code);
    assign bus_b.cmp = bus_b.cmp_en && (vin_b >= bus_b.dac_code);

    saradc_sar_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    saradc_sar_ctrl #(.NBITS(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Observation results for DUT A
    int          done_cnt;
    int          done_cyc [0:3];
    logic [7:0]  done_dat [0:3];
    logic [63:0] samp_mask;
    int          busy_low;
    int          inv_bad;
    int          ntr;
    logic [7:0]  trials [0:15];

    logic [7:0] exp_a5 [0:7] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in cycle 1; watches cycles 1..ncyc, driving start from smask
    task automatic observe(input int ncyc, input logic [63:0] smask, input logic [7:0] vin_after);
        done_cnt  = 0;
        samp_mask = '0;
        busy_low  = 0;
        inv_bad   = 0;
        ntr       = 0;
        for (int i = 0; i < 4; i++) begin
            done_cyc[i] = 0;
            done_dat[i] = '0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            bus_a.start = smask[c];
            if ((bus_a.dac_code_n !== ~bus_a.dac_code) || (bus_a.sample && bus_a.cmp_en))
                inv_bad++;
            if (bus_a.sample) samp_mask[c] = 1'b1;
            if (!bus_a.busy) busy_low++;
            if (bus_a.cmp_en && ntr < 16) begin
                trials[ntr] = bus_a.dac_code;
                ntr++;
            end
            if (bus_a.done) begin
                if (done_cnt < 4) begin
                    done_cyc[done_cnt] = c;
                    done_dat[done_cnt] = bus_a.data;
                end
                done_cnt++;
                vin_a = vin_after;
            end
            tick();
        end
        bus_a.start = 1'b0;
    endtask

    initial begin
        int          b_done_cyc;
        int          b_done_cnt;
        logic [3:0]  b_data;
        logic [15:0] b_cmp_mask;
        int          guard;

        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        vin_a       = 8'h00;
        vin_b       = 4'h0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_sample",   bus_a.sample,     1'b0);
        chk("rst_cmp_en",   bus_a.cmp_en,     1'b0);
        chk("rst_busy",     bus_a.busy,       1'b0);
        chk("rst_done",     bus_a.done,       1'b0);
        chk("rst_dac",      bus_a.dac_code,   8'h00);
        chk("rst_dac_n",    bus_a.dac_code_n, 8'hFF);
        chk("rst_data",     bus_a.data,       8'h00);
        chk("rst_b_dac_n",  bus_b.dac_code_n, 4'hF);
        rst = 1'b0;
        tick();
        chk("idle_busy", bus_a.busy, 1'b0);

        // Nominal conversion of 0xA5
        vin_a = 8'hA5;
        bus_a.start = 1'b1;
        tick();
        observe(24, 64'h0, 8'hA5);
        chk("a5_done_cnt",  done_cnt,    1);
        chk("a5_done_cyc",  done_cyc[0], 19);
        chk("a5_data",      done_dat[0], 8'hA5);
        chk("a5_samp_mask", samp_mask,   64'h6);
        chk("a5_ntr",       ntr,         8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("a5_trial%0d", i), trials[i], exp_a5[i]);
        chk("a5_invariants", inv_bad, 0);
        chk("a5_hold_data", bus_a.data, 8'hA5);

        // Endpoints
        vin_a = 8'h00;
        bus_a.start = 1'b1;
        tick();
        observe(22, 64'h0, 8'h00);
        chk("zero_done_cyc", done_cyc[0], 19);
        chk("zero_data",     done_dat[0], 8'h00);
        chk("zero_inv",      inv_bad,     0);

        vin_a = 8'hFF;
        bus_a.start = 1'b1;
        tick();
        observe(22, 64'h0, 8'hFF);
        chk("ff_done_cyc", done_cyc[0], 19);
        chk("ff_data",     done_dat[0], 8'hFF);
        chk("ff_inv",      inv_bad,     0);

        // start held high, vin steps after the first result
        vin_a = 8'h3C;
        bus_a.start = 1'b1;
        tick();
        observe(45, 64'hFFFF_FFFF_FFFF_FFFF, 8'hC3);
        chk("held_done_cnt", done_cnt,                  2);
        chk("held_gap",      done_cyc[1] - done_cyc[0], 20);
        chk("held_data0",    done_dat[0],               8'h3C);
        chk("held_data1",    done_dat[1],               8'hC3);
        chk("held_busy_low", busy_low,                  2);
        chk("held_inv",      inv_bad,                   0);
        guard = 0;
        while (bus_a.busy && guard < 40) begin
            tick();
            guard++;
        end
        chk("held_drain", bus_a.busy, 1'b0);

        // start pulses in cycles 5 and 19 are ignored
        vin_a = 8'h66;
        bus_a.start = 1'b1;
        tick();
        observe(30, (64'h1 << 5) | (64'h1 << 19), 8'h66);
        chk("ign_done_cnt",  done_cnt,    1);
        chk("ign_done_cyc",  done_cyc[0], 19);
        chk("ign_data",      done_dat[0], 8'h66);
        chk("ign_samp_mask", samp_mask,   64'h6);
        chk("ign_busy_low",  busy_low,    11);

        // Reset in cycle 10 of a 0x5A conversion
        vin_a = 8'h5A;
        bus_a.start = 1'b1;
        tick();
        observe(9, 64'h0, 8'h5A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy",   bus_a.busy,     1'b0);
        chk("mid_sample", bus_a.sample,   1'b0);
        chk("mid_cmp_en", bus_a.cmp_en,   1'b0);
        chk("mid_dac",    bus_a.dac_code, 8'h00);
        chk("mid_data",   bus_a.data,     8'h00);
        chk("mid_done",   bus_a.done,     1'b0);
        tick();
        observe(20, 64'h0, 8'h5A);
        chk("mid_no_done", done_cnt, 0);
        bus_a.start = 1'b1;
        tick();
        observe(22, 64'h0, 8'h5A);
        chk("post_done_cyc", done_cyc[0], 19);
        chk("post_data",     done_dat[0], 8'h5A);

        // Small configuration: NBITS=4, SAMPLE=1, SETTLE=0
        vin_b       = 4'h9;
        b_done_cyc  = 0;
        b_done_cnt  = 0;
        b_data      = '0;
        b_cmp_mask  = '0;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (bus_b.cmp_en) b_cmp_mask[c] = 1'b1;
            if (bus_b.sample && bus_b.cmp_en) b_done_cnt += 100;
            if (bus_b.done) begin
                b_done_cyc = c;
                b_data     = bus_b.data;
                b_done_cnt++;
            end
            tick();
        end
        chk("b_done_cnt",  b_done_cnt, 1);
        chk("b_done_cyc",  b_done_cyc, 6);
        chk("b_data",      b_data,     4'h9);
        chk("b_cmp_mask",  b_cmp_mask, 16'h003C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/saradc_sar_ctrl.md
Name: saradc_sar_ctrl

Overview:
- Synchronous successive-approximation controller for the SAR ADC macro.
- Drives the sampling-switch inverter (SARADC_CELL_INVX0_ASSW) and the capacitor-DAC bottom-plate drivers (SARADC_CELL_INVX16_ASCAP, one per bit).
- Strobes the comparator, resolves one bit per trial MSB-first, then publishes the code with a done pulse.
- Sits between the digital ADC wrapper (start/data/done) and the analog SAR array.

Parameters:
- NBITS, 8, conversion resolution and DAC bit count.
- SAMPLE_CYCLES, 2, clock cycles the sample switch is closed; legal range >= 1.
- SETTLE_CYCLES, 1, DAC settling cycles before each compare; legal range >= 0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- cmp  input  1  comparator decision: 1 = vin >= vdac. Valid while cmp_en is high.
- sample  output  1  sample switch enable, active-high, to the ASSW inverter input.
- cmp_en  output  1  comparator latch strobe.
- dac_code  output  NBITS  current trial code, MSB = bit NBITS-1.
- dac_code_n  output  NBITS  bitwise ~dac_code, drives the ASCAP inverter inputs. Combinational from the dac_code register.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; data is valid.
- data  output  NBITS  last conversion result, held until the next done.

Behaviour:
- Reset (rst=1 at an edge) forces the following, regardless of state:
  - state=IDLE
  - sample=0, cmp_en=0, busy=0, done=0
  - dac_code=0, so dac_code_n is all ones
  - data=0, all counters cleared
- All outputs are registered. The only exception is dac_code_n, which is the inverse of registered dac_code.
- FSM states: IDLE, SAMPLE, SETTLE, COMPARE, DONE.
- IDLE:
  - start=1 at an edge -> SAMPLE; the edge where this happens is T0.
  - Cycle n means the cycle after edge T0+n-1.
- SAMPLE, cycles 1..SAMPLE_CYCLES:
  - sample=1, busy=1, dac_code=0.
  - Then load dac_code = 1<<(NBITS-1), set bit index k=NBITS-1, and go to SETTLE.
  - If SETTLE_CYCLES=0, go directly to COMPARE.
- SETTLE: held SETTLE_CYCLES cycles, cmp_en=0, then -> COMPARE.
- COMPARE: exactly one cycle with cmp_en=1. At the exiting edge, cmp is registered and:
  - cmp=0: clear bit k; cmp=1: keep bit k.
  - If k>0: set bit k-1, decrement k, go to SETTLE (or COMPARE if SETTLE_CYCLES=0).
  - If k=0: data <= final code (with bit 0 resolved), go to DONE.
- Each bit trial takes SETTLE_CYCLES+1 cycles.
- DONE: one cycle with done=1 and busy=1. Then -> IDLE with busy=0 and dac_code=0.
  - done occurs in cycle SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+1) + 1, which is 19 for the defaults.
  - data is updated at the edge entering DONE, so it is valid in the done cycle.
- start handling:
  - start is ignored in every state except IDLE; there is no queuing.
  - With start held high continuously, a new conversion starts every SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+1) + 2 cycles (20 for the defaults).
- Mid-conversion reset:
  - Outputs take their reset values at the next edge.
  - No done is produced and data is cleared to 0.
- Output timing rules:
  - sample and cmp_en are never high in the same cycle.
  - dac_code changes only at SAMPLE->trial and COMPARE exit edges; it is stable through SETTLE and COMPARE.
- Counters: sample/settle counter width is clog2(max(SAMPLE_CYCLES, SETTLE_CYCLES)+1); bit index width is clog2(NBITS). There is no wrap-around: the counters are reloaded on every state entry.

Test Plan:
- Ideal comparator model cmp = (VIN >= dac_code) while cmp_en, VIN=0xA5, single start pulse -> sample high in cycles 1-2, done in cycle 19 only, data=0xA5. dac_code trial sequence: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- Endpoints: VIN=0x00 -> data=0x00; VIN=0xFF -> data=0xFF. dac_code_n == ~dac_code in every cycle; sample and cmp_en never both high.
- start held high with VIN stepping 0x3C then 0xC3 -> done pulses exactly 20 cycles apart with data=0x3C then 0xC3. busy is low for one cycle between conversions.
- start pulsed in cycles 5 and 19 of a conversion -> ignored. Exactly one done; no extra conversion begins.
- rst asserted in cycle 10 of a VIN=0x5A conversion -> next cycle: busy=0, sample=0, cmp_en=0, dac_code=0x00, data=0x00, and no done. A subsequent start converts 0x5A correctly.
- Parameter sweep NBITS=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=0, VIN=0x9 -> done in cycle 6, data=0x9, cmp_en high for 4 consecutive cycles.
